// File: rtl/icache_tag_ctrl_pkg.sv
// Shared types for the instruction-cache tag RAM controller.
package icache_tag_ctrl_pkg;

  // Controller FSM: power-up sweep, normal arbitration, flush sweep.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2
  } tag_ctrl_state_e;

  // Round-robin pointer: records which requester was granted most recently.
  typedef enum logic {
    RR_LOOKUP_LAST = 1'b0,
    RR_REFILL_LAST = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/icache_tag_ram_ctrl.sv
// Arbiter and sequencer for one single-port instruction-cache tag RAM bank.
// Lookups (reads) and refills (writes) share the port; a full-bank
// invalidation sweep runs on flush request and optionally out of reset,
// since the tag SRAM powers up with undefined contents.
module icache_tag_ram_ctrl
  import icache_tag_ctrl_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = 7,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter bit          INIT_FLUSH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  lookup_req_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_gnt_o,
  output logic                  lookup_rvalid_o,
  output logic [TAG_WIDTH-1:0]  lookup_rdata_o,

  input  logic                  refill_req_i,
  input  logic [ADDR_WIDTH-1:0] refill_addr_i,
  input  logic [TAG_WIDTH-1:0]  refill_wdata_i,
  output logic                  refill_gnt_o,

  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,

  output logic                  ram_req_o,
  output logic                  ram_write_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [TAG_WIDTH-1:0]  ram_wdata_o,
  input  logic [TAG_WIDTH-1:0]  ram_rdata_i
);

  localparam tag_ctrl_state_e RESET_STATE = INIT_FLUSH ? INIT : IDLE;
  // The sweep ends on the last set instead of wrapping the counter.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  tag_ctrl_state_e       state, state_d;
  logic [ADDR_WIDTH-1:0] counter, counter_d;
  rr_ptr_e               rr_last, rr_last_d;
  logic                  lookup_rvalid_q;
  logic                  flush_ack_q, flush_ack_d;
  logic                  lookup_gnt, refill_gnt;

  // State, sweep counter, arbitration pointer and registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RESET_STATE;
      counter         <= '0;
      rr_last         <= RR_REFILL_LAST;
      lookup_rvalid_q <= 1'b0;
      flush_ack_q     <= 1'b0;
    end else begin
      state           <= state_d;
      counter         <= counter_d;
      rr_last         <= rr_last_d;
      lookup_rvalid_q <= lookup_gnt;
      flush_ack_q     <= flush_ack_d;
    end
  end

  // Next state, zero-cycle arbitration and RAM port steering.
  // The flush request is ignored while its ack is high so a requester
  // that drops it in response to the ack cannot start a second sweep.
  always_comb begin
    state_d     = state;
    counter_d   = counter;
    rr_last_d   = rr_last;
    flush_ack_d = 1'b0;
    lookup_gnt  = 1'b0;
    refill_gnt  = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    case (state)
      INIT, SWEEP: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = counter;
        if (counter == LAST_ADDR) begin
          state_d     = IDLE;
          counter_d   = '0;
          flush_ack_d = (state == SWEEP);
        end else begin
          counter_d = counter + ADDR_ONE;
        end
      end

      IDLE: begin
        if (flush_req_i && !flush_ack_q) begin
          state_d   = SWEEP;
          counter_d = '0;
        end else if (lookup_req_i && (!refill_req_i || rr_last == RR_REFILL_LAST)) begin
          lookup_gnt = 1'b1;
          ram_req_o  = 1'b1;
          ram_addr_o = lookup_addr_i;
          rr_last_d  = RR_LOOKUP_LAST;
        end else if (refill_req_i) begin
          refill_gnt  = 1'b1;
          ram_req_o   = 1'b1;
          ram_write_o = 1'b1;
          ram_addr_o  = refill_addr_i;
          ram_wdata_o = refill_wdata_i;
          rr_last_d   = RR_REFILL_LAST;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign lookup_gnt_o    = lookup_gnt;
  assign refill_gnt_o    = refill_gnt;
  assign lookup_rvalid_o = lookup_rvalid_q;
  assign lookup_rdata_o  = ram_rdata_i;
  assign flush_ack_o     = flush_ack_q;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_icache_tag_ram_ctrl.sv
// Self-checking bench for icache_tag_ram_ctrl with a behavioural tag SRAM
// and a lookup scoreboard fed from the bench's own record of written tags.
module tb_icache_tag_ram_ctrl;

  localparam int TW    = 7;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_req = 1'b0;
  logic [AW-1:0] lookup_addr = '0;
  logic          lookup_gnt;
  logic          lookup_rvalid;
  logic [TW-1:0] lookup_rdata;
  logic          refill_req = 1'b0;
  logic [AW-1:0] refill_addr = '0;
  logic [TW-1:0] refill_wdata = '0;
  logic          refill_gnt;
  logic          flush_req = 1'b0;
  logic          flush_ack;
  logic          busy;
  logic          ram_req;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [TW-1:0] ram_wdata;
  logic [TW-1:0] ram_rdata = '0;

  int n_compared = 0;
  int n_failed   = 0;

  logic [TW-1:0] ram_mem [DEPTH];
  logic [TW-1:0] shadow  [DEPTH];
  logic [TW-1:0] exp_q [$];
  logic          prev_lookup_gnt = 1'b0;

  icache_tag_ram_ctrl #(
    .TAG_WIDTH (TW),
    .ADDR_WIDTH(AW),
    .INIT_FLUSH(1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_req_i   (lookup_req),
    .lookup_addr_i  (lookup_addr),
    .lookup_gnt_o   (lookup_gnt),
    .lookup_rvalid_o(lookup_rvalid),
    .lookup_rdata_o (lookup_rdata),
    .refill_req_i   (refill_req),
    .refill_addr_i  (refill_addr),
    .refill_wdata_i (refill_wdata),
    .refill_gnt_o   (refill_gnt),
    .flush_req_i    (flush_req),
    .flush_ack_o    (flush_ack),
    .busy_o         (busy),
    .ram_req_o      (ram_req),
    .ram_write_o    (ram_write),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Power-up garbage in the tag SRAM model.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] <= TW'($urandom);
  end

  // Single-port tag SRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) ram_mem[ram_addr] <= ram_wdata;
      else           ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Scoreboard: push the expected tag on each lookup grant, pop on rvalid.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_lookup_gnt = 1'b0;
    end else begin
      n_compared++;
      if (lookup_rvalid !== prev_lookup_gnt) begin
        n_failed++;
        $display("[TB] FAIL rvalid_timing at %0t: got %b expected %b", $time, lookup_rvalid, prev_lookup_gnt);
      end
      if (lookup_rvalid === 1'b1) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_failed++;
          $display("[TB] FAIL rdata_unexpected at %0t: got %h expected no read", $time, lookup_rdata);
        end else begin
          logic [TW-1:0] exp_tag;
          exp_tag = exp_q.pop_front();
          if (lookup_rdata !== exp_tag) begin
            n_failed++;
            $display("[TB] FAIL rdata at %0t: got %h expected %h", $time, lookup_rdata, exp_tag);
          end
        end
      end
      if (lookup_gnt === 1'b1) exp_q.push_back(shadow[lookup_addr]);
      if (refill_gnt === 1'b1) shadow[refill_addr] = refill_wdata;
      prev_lookup_gnt = (lookup_gnt === 1'b1);
    end
  end

  task automatic clear_shadow();
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values, power-up sweep of zeros over 0..63, then first tie to lookup.
  task automatic test_reset();
    rst_n = 1'b0;
    lookup_req = 1'b1; lookup_addr = 6'd3;
    refill_req = 1'b1; refill_addr = 6'd7; refill_wdata = 7'h2a;
    flush_req = 1'b0;
    clear_shadow();
    step(); step();
    @(negedge clk);
    n_compared++;
    if ({busy, lookup_rvalid, flush_ack, lookup_gnt, refill_gnt} !== 5'b10000) begin
      n_failed++;
      $display("[TB] FAIL reset_values: got %b expected %b", {busy, lookup_rvalid, flush_ack, lookup_gnt, refill_gnt}, 5'b10000);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW+TW+6:0] got, exp;
      @(negedge clk);
      got = {busy, ram_req, ram_write, ram_addr, ram_wdata, flush_ack, lookup_gnt, refill_gnt};
      exp = {1'b1, 1'b1, 1'b1, AW'(i), {TW{1'b0}}, 1'b0, 1'b0, 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_failed++;
        $display("[TB] FAIL init_sweep[%0d]: got %h expected %h", i, got, exp);
      end
      step();
    end
    @(negedge clk);
    n_compared++;
    if ({busy, flush_ack, lookup_gnt, refill_gnt} !== 4'b0010) begin
      n_failed++;
      $display("[TB] FAIL init_done: got %b expected %b", {busy, flush_ack, lookup_gnt, refill_gnt}, 4'b0010);
    end
    step();
    lookup_req = 1'b0;
    refill_req = 1'b0;
  endtask

  // Refill set 5 with 7'h45 then read it back.
  task automatic test_refill_lookup();
    refill_req = 1'b1; refill_addr = 6'd5; refill_wdata = 7'h45;
    @(negedge clk);
    n_compared++;
    if ({refill_gnt, lookup_gnt, ram_req, ram_write, ram_addr, ram_wdata} !== {4'b1011, 6'd5, 7'h45}) begin
      n_failed++;
      $display("[TB] FAIL refill_grant: got %h expected %h",
               {refill_gnt, lookup_gnt, ram_req, ram_write, ram_addr, ram_wdata}, {4'b1011, 6'd5, 7'h45});
    end
    step();
    refill_req = 1'b0;
    lookup_req = 1'b1; lookup_addr = 6'd5;
    @(negedge clk);
    n_compared++;
    if ({lookup_gnt, refill_gnt, ram_req, ram_write, ram_addr} !== {4'b1010, 6'd5}) begin
      n_failed++;
      $display("[TB] FAIL lookup_grant: got %h expected %h",
               {lookup_gnt, refill_gnt, ram_req, ram_write, ram_addr}, {4'b1010, 6'd5});
    end
    step();
    lookup_req = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({lookup_rvalid, lookup_rdata} !== {1'b1, 7'h45}) begin
      n_failed++;
      $display("[TB] FAIL refill_readback: got %h expected %h", {lookup_rvalid, lookup_rdata}, {1'b1, 7'h45});
    end
    step();
  endtask

  // Both requesters held: grants alternate L,R,L,R,L,R after a refill.
  task automatic test_round_robin();
    refill_req = 1'b1; refill_addr = 6'd9; refill_wdata = 7'h11;
    @(negedge clk);
    n_compared++;
    if (refill_gnt !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL rr_setup_refill: got %b expected 1", refill_gnt);
    end
    step();
    lookup_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp;
      lookup_addr  = (i == 0) ? 6'd9 : AW'(20 + i - 1);
      refill_addr  = AW'(20 + i);
      refill_wdata = TW'(8'h50 + i);
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_compared++;
      if ({lookup_gnt, refill_gnt} !== exp) begin
        n_failed++;
        $display("[TB] FAIL round_robin[%0d]: got %b expected %b", i, {lookup_gnt, refill_gnt}, exp);
      end
      step();
    end
    lookup_req = 1'b0;
    refill_req = 1'b0;
  endtask

  // Flush with a lookup pending: lookup stalls, one ack, all tags zero.
  task automatic test_flush_lookup_pending();
    clear_shadow();
    lookup_req = 1'b1; lookup_addr = 6'd21;
    flush_req = 1'b1;
    for (int c = 0; c <= DEPTH; c++) begin
      logic [3:0] exp;
      exp = {(c > 0), 3'b000};
      @(negedge clk);
      n_compared++;
      if ({busy, flush_ack, lookup_gnt, refill_gnt} !== exp) begin
        n_failed++;
        $display("[TB] FAIL flush_stall[%0d]: got %b expected %b", c, {busy, flush_ack, lookup_gnt, refill_gnt}, exp);
      end
      step();
    end
    @(negedge clk);
    n_compared++;
    if ({busy, flush_ack, lookup_gnt} !== 3'b011) begin
      n_failed++;
      $display("[TB] FAIL flush_ack_cycle: got %b expected %b", {busy, flush_ack, lookup_gnt}, 3'b011);
    end
    step();
    flush_req = 1'b0;
    lookup_req = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({busy, flush_ack} !== 2'b00) begin
      n_failed++;
      $display("[TB] FAIL flush_ack_pulse: got %b expected %b", {busy, flush_ack}, 2'b00);
    end
    step();
    for (int a = 0; a < DEPTH; a++) begin
      lookup_req = 1'b1; lookup_addr = AW'(a);
      @(negedge clk);
      n_compared++;
      if (lookup_gnt !== 1'b1) begin
        n_failed++;
        $display("[TB] FAIL readback_grant[%0d]: got %b expected 1", a, lookup_gnt);
      end
      step();
    end
    lookup_req = 1'b0;
    step();
  endtask

  // Flush held through the ack cycle then dropped: exactly one sweep.
  task automatic test_flush_hold();
    int ack_cnt, busy_cnt;
    ack_cnt = 0; busy_cnt = 0;
    flush_req = 1'b1;
    for (int c = 0; c < 160; c++) begin
      logic saw_ack;
      @(negedge clk);
      saw_ack = (flush_ack === 1'b1);
      if (saw_ack) ack_cnt++;
      if (busy === 1'b1) busy_cnt++;
      step();
      if (saw_ack) flush_req = 1'b0;
    end
    flush_req = 1'b0;
    n_compared++;
    if (ack_cnt != 1) begin
      n_failed++;
      $display("[TB] FAIL flush_hold_acks: got %0d expected 1", ack_cnt);
    end
    n_compared++;
    if (busy_cnt != DEPTH) begin
      n_failed++;
      $display("[TB] FAIL flush_hold_busy: got %0d expected %0d", busy_cnt, DEPTH);
    end
  endtask

  // Reset during flush sweep write 20: immediate reset values, INIT restarts at 0.
  task automatic test_reset_mid_sweep();
    bit found;
    found = 1'b0;
    flush_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && ram_addr === 6'd20) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_compared++;
    if (!found) begin
      n_failed++;
      $display("[TB] FAIL sweep_write20: got not reached expected reached");
    end
    #1;
    rst_n = 1'b0;
    flush_req = 1'b0;
    lookup_req = 1'b1; lookup_addr = 6'd21;
    refill_req = 1'b1; refill_addr = 6'd30; refill_wdata = 7'h7f;
    clear_shadow();
    #1;
    n_compared++;
    if ({busy, flush_ack, lookup_rvalid, lookup_gnt, refill_gnt, ram_addr} !== {5'b10000, 6'd0}) begin
      n_failed++;
      $display("[TB] FAIL mid_sweep_reset: got %h expected %h",
               {busy, flush_ack, lookup_rvalid, lookup_gnt, refill_gnt, ram_addr}, {5'b10000, 6'd0});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW+TW+6:0] got, exp;
      @(negedge clk);
      got = {busy, ram_req, ram_write, ram_addr, ram_wdata, flush_ack, lookup_gnt, refill_gnt};
      exp = {1'b1, 1'b1, 1'b1, AW'(i), {TW{1'b0}}, 1'b0, 1'b0, 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_failed++;
        $display("[TB] FAIL reinit_sweep[%0d]: got %h expected %h", i, got, exp);
      end
      step();
    end
    @(negedge clk);
    n_compared++;
    if ({busy, flush_ack, lookup_gnt, refill_gnt} !== 4'b0010) begin
      n_failed++;
      $display("[TB] FAIL reinit_done: got %b expected %b", {busy, flush_ack, lookup_gnt, refill_gnt}, 4'b0010);
    end
    step();
    lookup_req = 1'b0;
    refill_req = 1'b0;
    step(); step();
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_refill_lookup();
    test_round_robin();
    test_flush_lookup_pending();
    test_flush_hold();
    test_reset_mid_sweep();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/icache_tag_ram_ctrl.md
# icache_tag_ram_ctrl

Arbiter and sequencer for one single-port L1.5 instruction-cache tag RAM bank. Shares the RAM between the lookup path (tag reads) and the refill path (tag writes). Runs a full-bank invalidation sweep on flush request and, optionally, automatically after reset, because the tag SRAM powers up undefined. Sits between the L1.5 cache controller and the tag SRAM wrapper, with one instance per tag bank.

## Interface
- TAG_WIDTH, 7, tag entry width, valid bit included; a sweep writes all-zero entries.
- ADDR_WIDTH, 6, set-index width; bank depth is 2**ADDR_WIDTH.
- INIT_FLUSH, 1, when 1, run an invalidation sweep out of reset.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_req_i  in  1  tag-read request; held until granted.
- lookup_addr_i  in  ADDR_WIDTH  set index to read.
- lookup_gnt_o  out  1  read accepted this cycle.
- lookup_rvalid_o  out  1  lookup_rdata_o is valid.
- lookup_rdata_o  out  TAG_WIDTH  read tag.
- refill_req_i  in  1  tag-write request; held until granted.
- refill_addr_i  in  ADDR_WIDTH  set index to write.
- refill_wdata_i  in  TAG_WIDTH  tag to write.
- refill_gnt_o  out  1  write performed this cycle.
- flush_req_i  in  1  level request for a full invalidation; held until flush_ack_o.
- flush_ack_o  out  1  one-cycle pulse when the sweep is complete.
- busy_o  out  1  sweep in progress; no grants are issued.
- ram_req_o, ram_write_o  out  1 each  tag RAM request and write enable.
- ram_addr_o  out  ADDR_WIDTH  tag RAM address.
- ram_wdata_o  out  TAG_WIDTH  tag RAM write data.
- ram_rdata_i  in  TAG_WIDTH  tag RAM read data, one cycle after the read request.

## Operation
- FSM states:
  - INIT: entered from reset when INIT_FLUSH=1.
  - IDLE: normal arbitration.
  - SWEEP: invalidation sweep in progress.
- Reset goes to INIT when INIT_FLUSH=1, otherwise to IDLE.
- INIT and SWEEP behave identically:
  - A counter starts at 0 and issues one write per cycle (ram_req_o=1, ram_write_o=1, ram_addr_o=counter, ram_wdata_o=0).
  - After address 2**ADDR_WIDTH-1 is written, the FSM goes to IDLE.
  - On leaving SWEEP, flush_ack_o pulses. On leaving INIT there is no ack.
- IDLE, priority order:
  1. flush_req_i starts a sweep: go to SWEEP, counter=0, no grant this cycle.
  2. Otherwise, if exactly one of lookup and refill requests, grant it.
  3. If both request, round-robin: grant the one not granted last. The pointer resets to "refill last", so lookup wins the first tie.
- A granted lookup drives ram_req_o=1, ram_write_o=0, ram_addr_o=lookup_addr_i.
- A granted refill drives ram_req_o=1, ram_write_o=1, ram_addr_o=refill_addr_i, ram_wdata_o=refill_wdata_i.
- lookup_rdata_o is ram_rdata_i passed through, qualified by lookup_rvalid_o.
- flush_req_i is masked in the flush_ack_o cycle, so a requester dropping it on ack cannot retrigger a sweep.
- Same-address refill and lookup in the same cycle: arbitration decides the order. A lookup granted after the write returns the new tag; there is no bypass.
- Asynchronous reset mid-sweep aborts the sweep. The INIT sweep restarts from 0 if INIT_FLUSH=1.

## Timing
- Grants and ram_* outputs are combinational from the requests and state, with zero-cycle arbitration.
- lookup_rvalid_o is asserted exactly one cycle after lookup_gnt_o.
- Sweep duration is 2**ADDR_WIDTH cycles. flush_ack_o is registered and is high in the cycle after the last sweep write; that cycle is IDLE and grants may issue.
- busy_o is high in INIT and SWEEP.
- Reset values:
  - lookup_rvalid_o=0, flush_ack_o=0.
  - busy_o=1 if INIT_FLUSH, else 0.
  - Counter=0, round-robin pointer="refill last".
  - Grant outputs stay low until the FSM reaches IDLE.
- Counter wrap-around at 2**ADDR_WIDTH-1 is the sweep terminating condition. The counter must not wrap and continue.

## Structure
- Package icache_tag_ctrl_pkg:
  - FSM state enum (INIT, IDLE, SWEEP).
  - Round-robin pointer encoding.
- No sub-module: the sweep counter and arbiter are inline. The tag SRAM wrapper is instantiated by the parent, not inside this block.

## Test plan
- Reset with INIT_FLUSH=1, ADDR_WIDTH=6: busy_o=1 for 64 cycles, writes of 0 to addresses 0..63 in order, no flush_ack_o, busy_o=0 on cycle 65.
- Refill addr 5 = 7'h45, then lookup addr 5: lookup_rvalid_o one cycle after grant with rdata 7'h45.
- Lookup and refill held high together for 6 cycles: grants alternate L,R,L,R,L,R.
- flush_req_i in IDLE with lookup pending: no lookup grant for 64 cycles, flush_ack_o single pulse, lookup granted in the ack cycle, all tags read back 0.
- flush_req_i held through the ack cycle and dropped after: exactly one sweep.
- rst_n asserted at sweep write 20: outputs return to reset values immediately, and the INIT sweep restarts at address 0.
